// File: rtl/note_sequencer.sv
// note_sequencer: queues note requests and plays them back to back for the
// square-wave tone generator feeding the PmodAMP2.
//
// Each queued note occupies a slot of exactly beats*BEAT_TICKS cycles. The
// slot is a PLAY phase of beats*BEAT_TICKS - GAP_TICKS cycles followed by a
// silent GAP phase of GAP_TICKS cycles.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in_valid     note request valid
//   in_ready     FIFO can accept a note (low while full or during stop)
//   in_pitch     pitch code; 1..8 = C4..C5, anything else is a rest
//   in_beats     duration in beats; 0 is played as 8 beats
//   stop         synchronous abort: flush the FIFO and go silent
//   half_period  tone generator cycles per output toggle; 0 when silent
//   tone_en      tone generator run / amplifier enable
//   busy         a note slot is in progress
//   fifo_count   FIFO occupancy
module note_sequencer #(
    parameter int unsigned BEAT_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_pitch,
    input  logic [2:0]                    in_beats,
    input  logic                          stop,
    output logic [17:0]                   half_period,
    output logic                          tone_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TW = $clog2(8 * BEAT_TICKS + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    // Half-period lookup, round(100e6 / (2 f)). Rests map to 0.
    function automatic logic [17:0] pitch_lut(input logic [3:0] p);
        logic [17:0] hp;
        case (p)
            4'd1:    hp = 18'd191110;
            4'd2:    hp = 18'd170265;
            4'd3:    hp = 18'd151685;
            4'd4:    hp = 18'd143172;
            4'd5:    hp = 18'd127551;
            4'd6:    hp = 18'd113636;
            4'd7:    hp = 18'd101239;
            4'd8:    hp = 18'd95557;
            default: hp = 18'd0;
        endcase
        return hp;
    endfunction

    // Timer load for the PLAY phase; the timer counts down to 0 on the last cycle.
    function automatic logic [TW-1:0] play_load(input logic [2:0] b);
        int unsigned n;
        n = (b == 3'd0) ? 32'd8 : 32'(b);
        return TW'(n * BEAT_TICKS - GAP_TICKS - 1);
    endfunction

    // ------------------------------------------------------------------
    // Note FIFO
    // ------------------------------------------------------------------
    logic [6:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    logic [3:0]    head_pitch;
    logic [2:0]    head_beats;

    assign in_ready   = (count_q < DEPTH_C) && !stop;
    assign push       = in_valid && in_ready;
    assign head_pitch = mem_q[rd_ptr_q][6:3];
    assign head_beats = mem_q[rd_ptr_q][2:0];
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_pitch, in_beats};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (stop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        if (stop) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StPlay;
                        timer_d = play_load(head_beats);
                    end
                end
                StPlay: begin
                    if (timer_q == '0) begin
                        state_d = StGap;
                        timer_d = GAP_LOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                StGap: begin
                    if (timer_q == '0) begin
                        // Chain straight into the next note so slots stay back to back.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = StPlay;
                            timer_d = play_load(head_beats);
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next state so they line up
    // with the state register.
    // ------------------------------------------------------------------
    logic [17:0] note_hp_q, note_hp_d;
    logic [17:0] half_period_d;
    logic        tone_en_d, busy_d;

    always_comb begin
        note_hp_d     = pop ? pitch_lut(head_pitch) : note_hp_q;
        half_period_d = (state_d == StPlay) ? note_hp_d : 18'd0;
        tone_en_d     = (state_d == StPlay) && (note_hp_d != 18'd0);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_hp_q   <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            note_hp_q   <= note_hp_d;
            half_period <= half_period_d;
            tone_en     <= tone_en_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer with BEAT_TICKS=10, GAP_TICKS=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_pitch;
    logic [2:0]  in_beats;
    logic        stop;
    logic [17:0] half_period;
    logic        tone_en;
    logic        busy;
    logic [2:0]  fifo_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Variables for the fill-while-playing test.
    int unsigned hps[$];
    int unsigned exp_hps[6] = '{191110, 170265, 151685, 143172, 127551, 113636};
    bit          prev_ten;
    bit          saw_block;
    int unsigned max_cnt;
    int unsigned on_cycles;
    int unsigned budget;
    bit          accepted;

    note_sequencer #(
        .BEAT_TICKS (10),
        .GAP_TICKS  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pitch    (in_pitch),
        .in_beats    (in_beats),
        .stop        (stop),
        .half_period (half_period),
        .tone_en     (tone_en),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Check outputs for n consecutive cycles starting at the current falling edge.
    task automatic expect_span(input string tag, input int n, input logic ten,
                               input logic [17:0] hp, input logic bsy);
        for (int i = 0; i < n; i++) begin
            check({tag, "_ten"}, 32'(tone_en), 32'(ten));
            check({tag, "_hp"}, 32'(half_period), 32'(hp));
            check({tag, "_busy"}, 32'(busy), 32'(bsy));
            @(negedge clk);
        end
    endtask

    // Present one note for one cycle; returns at the next falling edge.
    task automatic drive_note(input logic [3:0] p, input logic [2:0] b);
        in_valid = 1'b1;
        in_pitch = p;
        in_beats = b;
        @(negedge clk);
    endtask

    task automatic queue_four();
        drive_note(4'd2, 3'd2);
        drive_note(4'd3, 3'd1);
        drive_note(4'd4, 3'd1);
        drive_note(4'd5, 3'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_pitch = '0;
        in_beats = '0;
        stop     = 1'b0;

        // Reset state
        #1;
        check("rst_ten", 32'(tone_en), 0);
        check("rst_hp", 32'(half_period), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(fifo_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(in_ready), 1);
        check("rel_busy", 32'(busy), 0);
        check("rel_cnt", 32'(fifo_count), 0);

        // Single note: A4, 2 beats -> 18 on, 2 gap, then idle
        drive_note(4'd6, 3'd2);
        in_valid = 1'b0;
        check("t1_cnt_queued", 32'(fifo_count), 1);
        check("t1_busy_pre", 32'(busy), 0);
        @(negedge clk);
        expect_span("t1_play", 18, 1'b1, 18'd113636, 1'b1);
        expect_span("t1_gap", 2, 1'b0, 18'd0, 1'b1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_ten_end", 32'(tone_en), 0);

        // Three 1-beat notes back to back, 30 cycles total
        @(negedge clk);
        drive_note(4'd1, 3'd1);
        drive_note(4'd3, 3'd1);
        check("t2_first_ten", 32'(tone_en), 1);
        check("t2_first_hp", 32'(half_period), 191110);
        drive_note(4'd5, 3'd1);
        in_valid = 1'b0;
        expect_span("t2_n1", 7, 1'b1, 18'd191110, 1'b1);
        expect_span("t2_g1", 2, 1'b0, 18'd0, 1'b1);
        expect_span("t2_n2", 8, 1'b1, 18'd151685, 1'b1);
        expect_span("t2_g2", 2, 1'b0, 18'd0, 1'b1);
        expect_span("t2_n3", 8, 1'b1, 18'd127551, 1'b1);
        expect_span("t2_g3", 2, 1'b0, 18'd0, 1'b1);
        check("t2_busy_end", 32'(busy), 0);

        // Six notes held on in_valid while the first plays
        @(negedge clk);
        prev_ten  = 1'b0;
        saw_block = 1'b0;
        max_cnt   = 0;
        on_cycles = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_pitch = 4'(i + 1);
                    in_beats = 3'd1;
                    in_valid = 1'b1;
                    accepted = 1'b0;
                    budget   = 0;
                    while (!accepted && budget < 100) begin
                        accepted = in_ready;
                        if (!in_ready) saw_block = 1'b1;
                        @(negedge clk);
                        budget++;
                    end
                    if (!accepted) check("t3_push_timeout", 0, 1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 90; c++) begin
                    if (tone_en && !prev_ten) hps.push_back(32'(half_period));
                    if (tone_en) on_cycles++;
                    prev_ten = tone_en;
                    if (32'(fifo_count) > max_cnt) max_cnt = 32'(fifo_count);
                    if (fifo_count == 3'd4) check("t3_full_ready", 32'(in_ready), 0);
                    @(negedge clk);
                end
            end
        join
        check("t3_notes", hps.size(), 6);
        for (int i = 0; i < hps.size() && i < 6; i++) begin
            check("t3_order", hps[i], exp_hps[i]);
        end
        check("t3_on_cycles", on_cycles, 48);
        check("t3_max_cnt", max_cnt, 4);
        check("t3_blocked", 32'(saw_block), 1);
        check("t3_busy_end", 32'(busy), 0);

        // Rests: pitch 0 for 3 beats then pitch 12 for 1 beat
        drive_note(4'd0, 3'd3);
        drive_note(4'd12, 3'd1);
        in_valid = 1'b0;
        expect_span("t4_rest", 40, 1'b0, 18'd0, 1'b1);
        check("t4_busy_end", 32'(busy), 0);

        // beats=0 plays as 8 beats
        drive_note(4'd6, 3'd0);
        in_valid = 1'b0;
        @(negedge clk);
        expect_span("t5_play", 78, 1'b1, 18'd113636, 1'b1);
        expect_span("t5_gap", 2, 1'b0, 18'd0, 1'b1);
        check("t5_busy_end", 32'(busy), 0);

        // stop mid-PLAY with three notes queued
        queue_four();
        check("t6_cnt_pre", 32'(fifo_count), 3);
        check("t6_ten_pre", 32'(tone_en), 1);
        check("t6_hp_pre", 32'(half_period), 170265);
        repeat (2) @(negedge clk);
        stop     = 1'b1;
        in_valid = 1'b1;
        in_pitch = 4'd7;
        in_beats = 3'd1;
        #1;
        check("t6_ready_stop", 32'(in_ready), 0);
        @(negedge clk);
        stop     = 1'b0;
        in_valid = 1'b0;
        check("t6_ten", 32'(tone_en), 0);
        check("t6_hp", 32'(half_period), 0);
        check("t6_cnt", 32'(fifo_count), 0);
        check("t6_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("t6_busy_later", 32'(busy), 0);
        check("t6_cnt_later", 32'(fifo_count), 0);

        // Same again with an asynchronous reset pulse
        queue_four();
        repeat (2) @(negedge clk);
        check("t7_ten_pre", 32'(tone_en), 1);
        check("t7_cnt_pre", 32'(fifo_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_ten", 32'(tone_en), 0);
        check("t7_hp", 32'(half_period), 0);
        check("t7_cnt", 32'(fifo_count), 0);
        check("t7_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t7_ready", 32'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("t7_busy_later", 32'(busy), 0);
        check("t7_ten_later", 32'(tone_en), 0);
        check("t7_cnt_later", 32'(fifo_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream stage of the square-wave tone generator that drives the PmodAMP2.
- Accepts note requests (pitch code + duration in beats) over a valid/ready handshake into a small FIFO.
- Plays the queued notes back to back, with a short articulation gap at the end of each note.
- Per note, presents the tone generator's half-period count (clock cycles per output toggle) and a tone enable.

Parameters:
- BEAT_TICKS, 12_500_000: clock cycles per beat (125 ms at 100 MHz).
- GAP_TICKS, 1_000_000: silent cycles at the end of each note. Must satisfy 1 <= GAP_TICKS < BEAT_TICKS.
- FIFO_DEPTH, 4: note FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  note request valid.
- in_ready  out  1  FIFO can accept a note.
- in_pitch  in  4  pitch code.
- in_beats  in  3  duration in beats; 0 means 8.
- stop  in  1  synchronous abort: flush and silence.
- half_period  out  18  cycles per output toggle for the tone generator; 0 when silent.
- tone_en  out  1  tone generator run / amplifier enable.
- busy  out  1  a note slot is in progress.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, tone_en=0, half_period=0, busy=0, fifo_count=0, in_ready=1 after release. All outputs registered.
- Pitch lookup, value = round(100e6/(2f)):
  - 1 C4 = 191110
  - 2 D4 = 170265
  - 3 E4 = 151685
  - 4 F4 = 143172
  - 5 G4 = 127551
  - 6 A4 = 113636
  - 7 B4 = 101239
  - 8 C5 = 95557
  - 0 and 9-15 are rests: tone_en=0, half_period=0 for the whole slot.
- Handshake:
  - in_ready = (fifo_count < FIFO_DEPTH) && !stop.
  - Push occurs when in_valid && in_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A full FIFO never drops or overwrites an entry.
- FSM states: IDLE, PLAY, GAP.
  - IDLE with FIFO non-empty: pop the head that cycle; next cycle go to PLAY.
  - A note pushed into an empty FIFO while IDLE reaches PLAY 2 cycles after the push edge.
  - PLAY: tone_en=1 and half_period=lookup for pitched codes. Lasts exactly beats*BEAT_TICKS - GAP_TICKS cycles, then go to GAP.
  - GAP: tone_en=0, half_period=0 for exactly GAP_TICKS cycles.
  - Last GAP cycle, FIFO non-empty: pop; next cycle PLAY. Notes are strictly back to back, each slot exactly beats*BEAT_TICKS cycles.
  - Last GAP cycle, FIFO empty: go to IDLE.
- busy = (state != IDLE).
- Timer: single down-counter, width $clog2(8*BEAT_TICKS+1). Loaded on state entry; no wrap.
- stop (highest priority, any state):
  - Next cycle: FIFO flushed (fifo_count=0), state IDLE, tone_en=0, half_period=0.
  - A push presented during the stop cycle is refused (in_ready=0).
- Reset mid-note: immediate silence and empty FIFO; no partial note resumes.
- in_beats=0 is played as 8 beats, never as zero length.

Test Plan (bench: BEAT_TICKS=10, GAP_TICKS=2):
- After reset, push {pitch=6, beats=2} -> PLAY starts 2 cycles later; tone_en=1 with half_period=113636 for 18 cycles, then 0/0 for 2 cycles; busy drops the following cycle.
- Push 3 notes back to back {1,1},{3,1},{5,1} -> tone_en highs of 8 cycles with half_periods 191110, 151685, 127551; each followed by a 2-cycle gap; no extra idle cycle between slots; total 30 cycles.
- Hold in_valid high with 6 notes while the first plays -> in_ready falls when fifo_count=4; no entry lost; all 6 play in order.
- Push {pitch=0, beats=3} then {pitch=12, beats=1} -> tone_en=0, half_period=0 for 40 cycles, busy=1 throughout.
- Push {6, beats=0} -> tone_en high 78 cycles, gap 2 cycles.
- Pulse stop mid-PLAY with 3 notes queued -> next cycle tone_en=0, half_period=0, fifo_count=0, busy=0; in_valid during the stop cycle not accepted. Repeat with rst_n pulsed low -> same outputs asynchronously.
